// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - operand read, writeback and register-file bus bundle
interface regfile_access_ctrl_if;
  logic        i_rd_req_valid;
  logic        o_rd_req_ready;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        o_rd_rsp_valid;
  logic        i_rd_rsp_ready;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [4:0]  o_rf_read_register_1;
  logic [4:0]  o_rf_read_register_2;
  logic [4:0]  o_rf_write_register;
  logic [31:0] o_rf_write_data;
  logic        o_rf_we;
  logic [31:0] i_rf_read_data_1;
  logic [31:0] i_rf_read_data_2;

  modport slave (
    input  i_rd_req_valid, i_rs1, i_rs2, i_rd_rsp_ready,
    input  i_wb_valid, i_wb_rd, i_wb_data,
    input  i_rf_read_data_1, i_rf_read_data_2,
    output o_rd_req_ready, o_rd_rsp_valid, o_rs1_data, o_rs2_data,
    output o_wb_ready, o_rf_read_register_1, o_rf_read_register_2,
    output o_rf_write_register, o_rf_write_data, o_rf_we
  );

  modport master (
    output i_rd_req_valid, i_rs1, i_rs2, i_rd_rsp_ready,
    output i_wb_valid, i_wb_rd, i_wb_data,
    output i_rf_read_data_1, i_rf_read_data_2,
    input  o_rd_req_ready, o_rd_rsp_valid, o_rs1_data, o_rs2_data,
    input  o_wb_ready, o_rf_read_register_1, o_rf_read_register_2,
    input  o_rf_write_register, o_rf_write_data, o_rf_we
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - arbitrates operand reads and writebacks onto a 2R1W register file
module regfile_access_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  regfile_access_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state;
  logic [2:0]  starve_cnt;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rsp_valid;

  logic idle;
  logic wb_wins;
  logic rd_ready;
  logic wb_ready;
  logic rd_accept;
  logic wb_accept;

  // Writes win unless a waiting read has already lost STARVE_LIMIT times in a row.
  assign idle      = (state == IDLE);
  assign wb_wins   = bus.i_wb_valid && (starve_cnt < LIMIT);
  assign rd_ready  = !i_reset && idle && !wb_wins;
  assign wb_ready  = !i_reset && !(idle && bus.i_rd_req_valid && !wb_wins);
  assign rd_accept = bus.i_rd_req_valid && rd_ready;
  assign wb_accept = bus.i_wb_valid && wb_ready;

  assign bus.o_rd_req_ready       = rd_ready;
  assign bus.o_wb_ready           = wb_ready;
  assign bus.o_rf_read_register_1 = rd_accept ? bus.i_rs1 : rs1_q;
  assign bus.o_rf_read_register_2 = rd_accept ? bus.i_rs2 : rs2_q;
  assign bus.o_rf_we              = wb_accept && (bus.i_wb_rd != 5'd0);
  assign bus.o_rf_write_register  = bus.i_wb_rd;
  assign bus.o_rf_write_data      = bus.i_wb_data;
  assign bus.o_rd_rsp_valid       = rsp_valid;
  assign bus.o_rs1_data           = rs1_data;
  assign bus.o_rs2_data           = rs2_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (!bus.i_rd_req_valid || rd_accept) begin
        starve_cnt <= '0;
      end else if (idle && wb_wins) begin
        starve_cnt <= starve_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (rd_accept) begin
            rs1_q <= bus.i_rs1;
            rs2_q <= bus.i_rs2;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // RF read data is held while a write is in flight, so a CAPTURE-cycle write cannot leak in.
          rs1_data  <= (rs1_q == 5'd0) ? 32'd0 : bus.i_rf_read_data_1;
          rs2_data  <= (rs2_q == 5'd0) ? 32'd0 : bus.i_rf_read_data_2;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.i_rd_rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - randomized and directed bench for regfile_access_ctrl
module tb_regfile_access_ctrl;
  localparam int STARVE_LIMIT = 4;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Register file environment; x0 holds junk so the forced-zero path is visible.
  logic [31:0] rf_mem [32] = '{0: 32'hBAD0_BAD0, default: 32'h0};
  always @(posedge i_clk) begin
    if (bus.o_rf_we) begin
      if (bus.o_rf_write_register != 5'd0) rf_mem[bus.o_rf_write_register] <= bus.o_rf_write_data;
    end else begin
      bus.i_rf_read_data_1 <= rf_mem[bus.o_rf_read_register_1];
      bus.i_rf_read_data_2 <= rf_mem[bus.o_rf_read_register_2];
    end
  end

  // Reference model: architectural registers plus a phase count since read acceptance.
  logic [31:0] ref_regs [32];
  int          ph;
  int          starve;
  logic [31:0] snap1, snap2, shown1, shown2;
  logic [4:0]  last_rr1, last_rr2;

  int          n_checks;
  int          n_fail;
  logic        obs_rd_acc, obs_wb_acc, obs_rsp_hs, obs_we;
  logic [31:0] obs_rs1, obs_rs2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic er, ew, racc, wacc, ewe, rd_wins_now;
    @(negedge i_clk);
    rd_wins_now = !(bus.i_wb_valid && (starve < STARVE_LIMIT));
    er   = !i_reset && (ph == 0) && rd_wins_now;
    ew   = !i_reset && !((ph == 0) && bus.i_rd_req_valid && rd_wins_now);
    racc = bus.i_rd_req_valid && er;
    wacc = bus.i_wb_valid && ew;
    ewe  = wacc && (bus.i_wb_rd != 5'd0);
    check("rd_req_ready", 32'(bus.o_rd_req_ready), 32'(er));
    check("wb_ready", 32'(bus.o_wb_ready), 32'(ew));
    check("rf_we", 32'(bus.o_rf_we), 32'(ewe));
    check("rsp_valid", 32'(bus.o_rd_rsp_valid), 32'(ph == 2));
    check("rf_rreg1", 32'(bus.o_rf_read_register_1), 32'(racc ? bus.i_rs1 : last_rr1));
    check("rf_rreg2", 32'(bus.o_rf_read_register_2), 32'(racc ? bus.i_rs2 : last_rr2));
    check("rs1_data", bus.o_rs1_data, shown1);
    check("rs2_data", bus.o_rs2_data, shown2);
    if (ewe) begin
      check("rf_wreg", 32'(bus.o_rf_write_register), 32'(bus.i_wb_rd));
      check("rf_wdata", bus.o_rf_write_data, bus.i_wb_data);
    end
    obs_rd_acc = bus.i_rd_req_valid && bus.o_rd_req_ready;
    obs_wb_acc = bus.i_wb_valid && bus.o_wb_ready;
    obs_rsp_hs = bus.o_rd_rsp_valid && bus.i_rd_rsp_ready;
    obs_we     = bus.o_rf_we;
    obs_rs1    = bus.o_rs1_data;
    obs_rs2    = bus.o_rs2_data;
    @(posedge i_clk);
    if (i_reset) begin
      ph = 0; starve = 0; shown1 = 0; shown2 = 0; last_rr1 = 0; last_rr2 = 0;
    end else begin
      if (!bus.i_rd_req_valid || racc) starve = 0;
      else if (ph == 0 && !rd_wins_now) starve = starve + 1;
      if (racc) begin
        snap1 = (bus.i_rs1 == 0) ? 32'd0 : ref_regs[bus.i_rs1];
        snap2 = (bus.i_rs2 == 0) ? 32'd0 : ref_regs[bus.i_rs2];
        last_rr1 = bus.i_rs1;
        last_rr2 = bus.i_rs2;
        ph = 1;
      end else if (ph == 1) begin
        shown1 = snap1;
        shown2 = snap2;
        ph = 2;
      end else if (ph == 2 && bus.i_rd_rsp_ready) begin
        ph = 0;
      end
      if (ewe) ref_regs[bus.i_wb_rd] = bus.i_wb_data;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_rd_req_valid = 0; bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rd_rsp_ready = 1;
    bus.i_wb_valid = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] data, output logic we_seen);
    bit done;
    done = 0;
    we_seen = 0;
    bus.i_wb_valid = 1; bus.i_wb_rd = rd; bus.i_wb_data = data;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = obs_wb_acc;
      we_seen = obs_we;
    end
    bus.i_wb_valid = 0;
    if (!done) check("wb_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output logic [31:0] d1, output logic [31:0] d2);
    bit done;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = obs_rsp_hs;
    end
    if (!done) check("rsp_timeout", 0, 1);
    d1 = obs_rs1;
    d2 = obs_rs2;
  endtask

  task automatic do_read(input logic [4:0] r1, input logic [4:0] r2,
                         output logic [31:0] d1, output logic [31:0] d2);
    bit done;
    done = 0;
    bus.i_rd_req_valid = 1; bus.i_rs1 = r1; bus.i_rs2 = r2; bus.i_rd_rsp_ready = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = obs_rd_acc;
    end
    bus.i_rd_req_valid = 0;
    if (!done) check("rd_accept_timeout", 0, 1);
    wait_rsp(d1, d2);
  endtask

  initial begin
    logic [31:0] d1, d2;
    logic        we_seen;
    int          wb_cnt, rd_at, acc_cnt;

    n_checks = 0; n_fail = 0;
    ph = 0; starve = 0; snap1 = 0; snap2 = 0; shown1 = 0; shown2 = 0;
    last_rr1 = 0; last_rr2 = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 0;

    // Reset with a write already pending; it must wait for release.
    i_reset = 1;
    idle_inputs();
    bus.i_wb_valid = 1; bus.i_wb_rd = 5'd3; bus.i_wb_data = 32'h3333_3333;
    repeat (2) @(posedge i_clk);
    #1;
    cycle();
    cycle();
    i_reset = 0;
    cycle();
    check("first_wb_after_reset", 32'(obs_wb_acc), 1);
    bus.i_wb_valid = 0;

    // Write then read back with rs2 = x0.
    do_write(5'd5, 32'hDEAD_BEEF, we_seen);
    check("x5_write_we", 32'(we_seen), 1);
    do_read(5'd5, 5'd0, d1, d2);
    check("x5_read_rs1", d1, 32'hDEAD_BEEF);
    check("x5_read_rs2", d2, 32'h0);

    // Read and write contend: STARVE_LIMIT writes first, then the read.
    bus.i_rd_req_valid = 1; bus.i_rs1 = 5'd5; bus.i_rs2 = 5'd9;
    bus.i_wb_valid = 1; bus.i_wb_rd = 5'd9; bus.i_rd_rsp_ready = 1;
    wb_cnt = 0; rd_at = 0;
    for (int c = 1; c <= 6; c++) begin
      bus.i_wb_data = $urandom;
      cycle();
      if (obs_rd_acc) begin
        rd_at = c;
        bus.i_rd_req_valid = 0;
      end
      if (obs_wb_acc && c <= 4) wb_cnt++;
      if (c == 6) check("starve_wb_resume", 32'(obs_wb_acc), 1);
    end
    bus.i_wb_valid = 0;
    check("starve_wb_count", 32'(wb_cnt), 4);
    check("starve_rd_cycle", 32'(rd_at), 5);
    wait_rsp(d1, d2);
    check("starve_rd_rs1", d1, 32'hDEAD_BEEF);

    // Write during CAPTURE must not disturb the pending response.
    do_write(5'd7, 32'h11, we_seen);
    bus.i_rd_req_valid = 1; bus.i_rs1 = 5'd7; bus.i_rs2 = 5'd5; bus.i_rd_rsp_ready = 0;
    cycle();
    check("x7_rd_accept", 32'(obs_rd_acc), 1);
    bus.i_rd_req_valid = 0;
    bus.i_wb_valid = 1; bus.i_wb_rd = 5'd7; bus.i_wb_data = 32'h22;
    cycle();
    check("x7_capture_wb", 32'(obs_wb_acc), 1);
    bus.i_wb_valid = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("x7_held_rs1", obs_rs1, 32'h11);
    end
    bus.i_rd_rsp_ready = 1;
    wait_rsp(d1, d2);
    check("x7_first_rs1", d1, 32'h11);
    do_read(5'd7, 5'd0, d1, d2);
    check("x7_second_rs1", d1, 32'h22);

    // x0 write is accepted without a register-file write.
    do_write(5'd0, 32'hFFFF_FFFF, we_seen);
    check("x0_write_we", 32'(we_seen), 0);
    do_read(5'd0, 5'd0, d1, d2);
    check("x0_read_rs1", d1, 32'h0);

    // Reset in CAPTURE discards the response.
    bus.i_rd_req_valid = 1; bus.i_rs1 = 5'd5; bus.i_rs2 = 5'd7;
    cycle();
    bus.i_rd_req_valid = 0;
    i_reset = 1;
    cycle();
    cycle();
    i_reset = 0;
    repeat (4) cycle();
    do_read(5'd5, 5'd7, d1, d2);
    check("post_reset_rs1", d1, 32'hDEAD_BEEF);
    check("post_reset_rs2", d2, 32'h22);

    // Back-to-back reads: one acceptance every three cycles.
    bus.i_rd_req_valid = 1; bus.i_rd_rsp_ready = 1;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      bus.i_rs1 = 5'($urandom);
      bus.i_rs2 = 5'($urandom);
      cycle();
      if (obs_rd_acc) acc_cnt++;
    end
    bus.i_rd_req_valid = 0;
    check("b2b_accept_count", 32'(acc_cnt), 4);

    // Random traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      i_reset            = ($urandom_range(0, 63) == 0);
      bus.i_rd_req_valid = 1'($urandom);
      bus.i_rs1          = 5'($urandom);
      bus.i_rs2          = 5'($urandom);
      bus.i_rd_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.i_wb_valid     = 1'($urandom);
      bus.i_wb_rd        = 5'($urandom);
      bus.i_wb_data      = $urandom;
      cycle();
    end
    i_reset = 0;
    idle_inputs();
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
